// File: rtl/quad_gate_pkg.sv
// Shared selector encodings and expected truth tables for the quad gate reference.
package quad_gate_pkg;

   localparam int SEL_W = 3;
   localparam int PAT_W = 4;
   localparam int TT_W  = 1 << PAT_W;

   typedef logic [SEL_W-1:0] gate_sel_t;

   localparam gate_sel_t GATE_AND  = 3'd0;
   localparam gate_sel_t GATE_OR   = 3'd1;
   localparam gate_sel_t GATE_NAND = 3'd2;
   localparam gate_sel_t GATE_NOR  = 3'd3;
   localparam gate_sel_t GATE_XOR  = 3'd4;
   localparam gate_sel_t GATE_XNOR = 3'd5;

   // Bit i holds gate(pattern=i), with A as the LSB of i.
   localparam logic [TT_W-1:0] TT_AND  = 16'h8000;
   localparam logic [TT_W-1:0] TT_OR   = 16'hFFFE;
   localparam logic [TT_W-1:0] TT_NAND = 16'h7FFF;
   localparam logic [TT_W-1:0] TT_NOR  = 16'h0001;
   localparam logic [TT_W-1:0] TT_XOR  = 16'h6996;
   localparam logic [TT_W-1:0] TT_XNOR = 16'h9669;

   // Reserved selectors map to an all-zero table.
   function automatic logic [TT_W-1:0] tt_lookup(gate_sel_t sel);
      logic [TT_W-1:0] tt;
      case (sel)
         GATE_AND:  tt = TT_AND;
         GATE_OR:   tt = TT_OR;
         GATE_NAND: tt = TT_NAND;
         GATE_NOR:  tt = TT_NOR;
         GATE_XOR:  tt = TT_XOR;
         GATE_XNOR: tt = TT_XNOR;
         default:   tt = '0;
      endcase
      return tt;
   endfunction

endpackage

// File: rtl/quad_gate_reference_if.sv
// Request/result bundle between an IC checker and the quad gate reference.
interface quad_gate_reference_if;
   import quad_gate_pkg::*;

   logic                in_valid;
   logic [PAT_W-1:0]    pattern;
   gate_sel_t           gate_select;

   logic                out_valid;
   logic                y;
   logic                y_and;
   logic                y_nand;
   logic                y_or;
   logic                y_nor;
   logic                y_xor;
   logic                y_xnor;
   logic [TT_W-1:0]     truth_table;
   logic                sel_ok;

   modport master (
      output in_valid, pattern, gate_select,
      input  out_valid, y, y_and, y_nand, y_or, y_nor, y_xor, y_xnor,
             truth_table, sel_ok
   );

   modport slave (
      input  in_valid, pattern, gate_select,
      output out_valid, y, y_and, y_nand, y_or, y_nor, y_xor, y_xnor,
             truth_table, sel_ok
   );

endinterface

// File: rtl/quad_gate_bank.sv
// Combinational evaluation of the six 4-input gates on one pattern.
module quad_gate_bank
   import quad_gate_pkg::*;
(
   input  logic [PAT_W-1:0] pattern,
   output logic             y_and,
   output logic             y_nand,
   output logic             y_or,
   output logic             y_nor,
   output logic             y_xor,
   output logic             y_xnor
);

   assign y_and  = &pattern;
   assign y_nand = ~y_and;
   assign y_or   = |pattern;
   assign y_nor  = ~y_or;
   assign y_xor  = ^pattern;
   assign y_xnor = ~y_xor;

endmodule

// File: rtl/quad_gate_reference.sv
// Registered golden-model unit: gate bank, select mux and one stage of result registers.
module quad_gate_reference
   import quad_gate_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   quad_gate_reference_if.slave bus
);

   logic            g_and, g_nand, g_or, g_nor, g_xor, g_xnor;
   logic            y_sel;
   logic            sel_valid;
   logic [TT_W-1:0] tt_sel;

   quad_gate_bank u_bank (
      .pattern (bus.pattern),
      .y_and   (g_and),
      .y_nand  (g_nand),
      .y_or    (g_or),
      .y_nor   (g_nor),
      .y_xor   (g_xor),
      .y_xnor  (g_xnor)
   );

   // Pick the requested gate; reserved selectors force y low and flag sel_ok=0.
   always_comb begin
      y_sel     = 1'b0;
      sel_valid = 1'b1;
      case (bus.gate_select)
         GATE_AND:  y_sel = g_and;
         GATE_OR:   y_sel = g_or;
         GATE_NAND: y_sel = g_nand;
         GATE_NOR:  y_sel = g_nor;
         GATE_XOR:  y_sel = g_xor;
         GATE_XNOR: y_sel = g_xnor;
         default:   sel_valid = 1'b0;
      endcase
      tt_sel = tt_lookup(bus.gate_select);
   end

   // Capture results on accepted requests; results hold while idle, reset beats in_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid   <= 1'b0;
         bus.y           <= 1'b0;
         bus.y_and       <= 1'b0;
         bus.y_nand      <= 1'b0;
         bus.y_or        <= 1'b0;
         bus.y_nor       <= 1'b0;
         bus.y_xor       <= 1'b0;
         bus.y_xnor      <= 1'b0;
         bus.truth_table <= '0;
         bus.sel_ok      <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.y           <= y_sel;
            bus.y_and       <= g_and;
            bus.y_nand      <= g_nand;
            bus.y_or        <= g_or;
            bus.y_nor       <= g_nor;
            bus.y_xor       <= g_xor;
            bus.y_xnor      <= g_xnor;
            bus.truth_table <= tt_sel;
            bus.sel_ok      <= sel_valid;
         end
      end
   end

endmodule

// File: tb/tb_quad_gate_reference.sv
// Randomized and directed check of quad_gate_reference against a behavioural model.
module tb_quad_gate_reference;

   logic clk = 1'b0;
   logic rst;

   quad_gate_reference_if bus();

   quad_gate_reference dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Model state: what each output should read after the most recent edge.
   bit        m_ov, m_y, m_and, m_nand, m_or, m_nor, m_xor, m_xnor, m_ok;
   bit [15:0] m_tt;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Gate behaviour from the rule table: counts of ones, not bit operators.
   function automatic bit gate_fn(int g, int p);
      int ones = $countones(p[3:0]);
      case (g)
         0: return ones == 4;
         1: return ones != 0;
         2: return ones != 4;
         3: return ones == 0;
         4: return (ones % 2) == 1;
         5: return (ones % 2) == 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit [15:0] table_fn(int g);
      bit [15:0] t = '0;
      for (int i = 0; i < 16; i++) t[i] = gate_fn(g, i);
      return t;
   endfunction

   task automatic model_step(input bit r, input bit v, input int p, input int g);
      if (r) begin
         {m_ov, m_y, m_and, m_nand, m_or, m_nor, m_xor, m_xnor, m_ok} = '0;
         m_tt = '0;
      end else begin
         m_ov = v;
         if (v) begin
            m_and  = gate_fn(0, p);
            m_or   = gate_fn(1, p);
            m_nand = gate_fn(2, p);
            m_nor  = gate_fn(3, p);
            m_xor  = gate_fn(4, p);
            m_xnor = gate_fn(5, p);
            m_ok   = (g <= 5);
            m_y    = gate_fn(g, p);
            m_tt   = table_fn(g);
         end
      end
   endtask

   task automatic check_all();
      chk("out_valid",   16'(bus.out_valid),   16'(m_ov));
      chk("y",           16'(bus.y),           16'(m_y));
      chk("y_and",       16'(bus.y_and),       16'(m_and));
      chk("y_nand",      16'(bus.y_nand),      16'(m_nand));
      chk("y_or",        16'(bus.y_or),        16'(m_or));
      chk("y_nor",       16'(bus.y_nor),       16'(m_nor));
      chk("y_xor",       16'(bus.y_xor),       16'(m_xor));
      chk("y_xnor",      16'(bus.y_xnor),      16'(m_xnor));
      chk("truth_table", bus.truth_table,      m_tt);
      chk("sel_ok",      16'(bus.sel_ok),      16'(m_ok));
   endtask

   // One cycle: drive on the falling edge, clock it in, compare 1 time unit later.
   task automatic apply(input bit r, input bit v, input int p, input int g);
      @(negedge clk);
      rst             = r;
      bus.in_valid    = v;
      bus.pattern     = 4'(p);
      bus.gate_select = 3'(g);
      @(posedge clk);
      model_step(r, v, p, g);
      #1;
      check_all();
   endtask

   initial begin
      rst             = 1'b1;
      bus.in_valid    = 1'b0;
      bus.pattern     = '0;
      bus.gate_select = '0;
      apply(1, 0, 0, 0);

      // Reset beats a simultaneous request.
      apply(1, 1, 15, 0);
      chk("rst_y", 16'(bus.y), 16'h0);

      // AND sweep, back-to-back.
      for (int p = 0; p < 16; p++) begin
         apply(0, 1, p, 0);
         chk("and_sweep_tt", bus.truth_table, 16'h8000);
         chk("and_sweep_y", 16'(bus.y), (p == 15) ? 16'h1 : 16'h0);
      end

      // NAND.
      apply(0, 1, 15, 2);
      chk("nand_y_f", 16'(bus.y), 16'h0);
      apply(0, 1, 7, 2);
      chk("nand_y_7", 16'(bus.y), 16'h1);
      chk("nand_tt", bus.truth_table, 16'h7FFF);

      // XOR / XNOR on 4'b1011.
      apply(0, 1, 11, 4);
      chk("xor_tt", bus.truth_table, 16'h6996);
      apply(0, 1, 11, 5);
      chk("xnor_tt", bus.truth_table, 16'h9669);

      // Reserved selector.
      apply(0, 1, 15, 7);
      chk("rsv_ok", 16'(bus.sel_ok), 16'h0);
      chk("rsv_and", 16'(bus.y_and), 16'h1);

      // Hold while idle, then reset.
      apply(0, 1, 0, 3);
      for (int i = 0; i < 3; i++) begin
         apply(0, 0, $urandom_range(15), $urandom_range(7));
         chk("hold_y", 16'(bus.y), 16'h1);
      end
      apply(1, 0, 0, 0);
      chk("hold_rst_y", 16'(bus.y), 16'h0);

      // Randomized traffic with occasional reset and idle cycles.
      for (int n = 0; n < 300; n++) begin
         apply(($urandom_range(19) == 0), ($urandom_range(3) != 0),
               $urandom_range(15), $urandom_range(7));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/quad_gate_reference.md
Name: quad_gate_reference

Overview:
Registered golden-model unit for the IC tester. It evaluates a 4-input AND, NAND, OR, NOR, XOR and XNOR on one 4-bit input pattern, then selects one result through a 3-bit gate selector. It also produces the full 16-entry expected truth table for the selected gate. The IC checker FSMs compare these values against the outputs of the device under test.

Parameters:
- SEL_W, 3, width of the gate selector.
- PAT_W, 4, width of the input pattern; fixed at 4, other values unsupported.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  qualifies pattern and gate_select for capture this cycle.
- pattern  input  4  stimulus: bit0=A, bit1=B, bit2=C, bit3=D.
- gate_select  input  3  0=AND, 1=OR, 2=NAND, 3=NOR, 4=XOR, 5=XNOR, 6/7 reserved.
- out_valid  output  1  one-cycle pulse; results below correspond to the last accepted request.
- y  output  1  selected gate output for the captured pattern.
- y_and, y_nand, y_or, y_nor, y_xor, y_xnor  output  1 each  individual gate results for the captured pattern.
- truth_table  output  16  expected output of the selected gate; bit i = gate(pattern=i).
- sel_ok  output  1  1 when the captured gate_select is 0..5.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: while rst=1 at a clock edge, every output clears to 0 (out_valid, y, all y_*, truth_table, sel_ok); inputs are ignored. Reset wins over a simultaneous in_valid.
- Gate functions, combinational on pattern:
  - AND = A&B&C&D; NAND = ~AND.
  - OR = A|B|C|D; NOR = ~OR.
  - XOR = odd parity of the 4 bits; XNOR = ~XOR.
- Latency: exactly 1 cycle. When in_valid=1 at edge N, all result registers load and out_valid=1 after edge N.
- When in_valid=0, out_valid=0 on the next edge; all other outputs hold their last values.
- No backpressure. Back-to-back in_valid on consecutive cycles is accepted every cycle with no bubbles.
- Select mux: y chooses the gate named by gate_select.
- truth_table encoding: bit i is computed from pattern value i (A = LSB of i). The 16-bit constants per select value are:
  - AND 16'h8000
  - OR 16'hFFFE
  - NAND 16'h7FFF
  - NOR 16'h0001
  - XOR 16'h6996
  - XNOR 16'h9669
- Reserved select (6, 7): y=0, truth_table=16'h0000, sel_ok=0. The individual y_* outputs remain valid.
- truth_table depends only on gate_select, not on pattern. It is captured on the same in_valid edge as the other results.
- Mid-operation reset: a request accepted on the same edge as rst=1 is discarded; outputs are 0 after that edge.
- No X propagation: every register has a defined reset value.

Decomposition:
- Shared package quad_gate_pkg holds:
  - gate-select constants GATE_AND=3'd0, GATE_OR=3'd1, GATE_NAND=3'd2, GATE_NOR=3'd3, GATE_XOR=3'd4, GATE_XNOR=3'd5;
  - the six 16-bit truth-table constants;
  - a typedef for the 3-bit selector.
- One sub-module: quad_gate_bank, purely combinational. It maps pattern[3:0] to the six gate outputs and is reused to generate the truth tables if constants are not used.
- Select mux and output registers live in the top.

Test Plan:
- Reset: drive rst=1 with in_valid=1, pattern=4'hF, gate_select=0 -> after the edge all outputs are 0 and out_valid=0.
- AND sweep: gate_select=0, pattern 0..15 back-to-back -> y=1 only for pattern 15; out_valid high on 16 consecutive cycles, each 1 cycle after its input; truth_table=16'h8000.
- NAND: gate_select=2, pattern=4'hF -> y=0, y_nand=0, y_and=1; pattern=4'h7 -> y=1; truth_table=16'h7FFF.
- XOR/XNOR: gate_select=4, pattern=4'b1011 -> y=1, truth_table=16'h6996; gate_select=5, same pattern -> y=0, truth_table=16'h9669.
- Reserved select: gate_select=7, pattern=4'hF -> y=0, sel_ok=0, truth_table=16'h0000, y_and=1, y_or=1.
- Hold/idle: accept pattern=4'h0 with select=3 (NOR, so y=1), then in_valid=0 for 3 cycles -> out_valid=0 and y stays 1; then rst=1 for one edge -> y=0.
